// File: rtl/charge_pkg.sv
// charge_pkg: shared types and the saturating-add helper for the accumulating
// charge store.
//   op_t      - stage-1 operation (accumulate or read)
//   state_t   - control FSM states (idle, drain stage 1, clear sweep)
//   sat_add() - signed add clamped to a w-bit range, with a clamp flag
package charge_pkg;

  typedef enum logic {OP_ACC, OP_RD} op_t;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SWEEP} state_t;

  typedef struct packed {
    logic signed [31:0] value;
    logic               sat;
  } sat_res_t;

  // a and b are sign-extended w-bit operands (w <= 32). The sum is formed one
  // bit wider than the operands so it can never wrap before it is compared
  // against the w-bit bounds. Landing exactly on a bound is not a clamp.
  function automatic sat_res_t sat_add(input logic signed [31:0] a,
                                       input logic signed [31:0] b,
                                       input int unsigned        w);
    logic signed [32:0] sum, hi, lo;
    sat_res_t r;
    sum     = {a[31], a} + {b[31], b};
    hi      = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo      = -(33'sd1 <<< (w - 1));
    r.value = sum[31:0];
    r.sat   = 1'b0;
    if (sum > hi) begin
      r.value = hi[31:0];
      r.sat   = 1'b1;
    end else if (sum < lo) begin
      r.value = lo[31:0];
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dp_ram_param.sv
// dp_ram_param: simple dual-port storage, one write port and one registered
// read port. A read and a write to the same address on the same edge return
// the old contents (read-before-write).
//   clk   - clock
//   we    - write enable; waddr/wdata - write address/data
//   raddr - read address, sampled every edge
//   q     - registered read data
module dp_ram_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end

endmodule

// File: rtl/charge_accum_ram.sv
// charge_accum_ram: per-neuron charge store with an internal saturating
// read-modify-write, a read(-and-clear) port and a whole-array clear sweep.
// One request is accepted per cycle (reads win); the RAM read happens at the
// accept edge and the result is written back at the end of the next cycle.
//   clk, reset      - clock, synchronous active-low reset
//   acc_*           - accumulate request (valid/ready, addr, signed addend)
//   rd_*            - read request (valid/ready, addr, clear-after-read)
//   rsp_valid/data  - read response, the cycle after the read is accepted
//   clr_start       - start a clear sweep (honoured in idle only)
//   clr_busy        - drain or sweep in progress, requests blocked
//   sat_event       - accumulate result was clamped
module charge_accum_ram
  import charge_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_val,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_clear,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              sat_event
);

  state_t                    state, state_nxt;
  logic [ADDR_W-1:0]         sweep_addr;
  logic                      sweep_last, sweeping;

  logic                      rd_fire, acc_fire;
  logic [ADDR_W-1:0]         req_addr;

  logic                      s1_valid;
  op_t                       s1_op;
  logic [ADDR_W-1:0]         s1_addr;
  logic signed [DATA_W-1:0]  s1_val;
  logic                      s1_clear;

  logic                      fwd_valid;
  logic [ADDR_W-1:0]         fwd_addr;
  logic [DATA_W-1:0]         fwd_data;

  logic [DATA_W-1:0]         ram_q;
  logic signed [DATA_W-1:0]  old_val, new_val;
  sat_res_t                  sres;
  logic                      s1_wr;
  logic                      sres_unused;

  logic                      we;
  logic [ADDR_W-1:0]         waddr;
  logic [DATA_W-1:0]         wdata;

  // ---------------- accept / arbitration ----------------
  assign rd_ready  = (state == S_IDLE);
  assign acc_ready = (state == S_IDLE) & ~rd_valid;
  assign rd_fire   = rd_valid & rd_ready;
  assign acc_fire  = acc_valid & acc_ready;
  assign req_addr  = rd_valid ? rd_addr : acc_addr;

  // ---------------- control FSM ----------------
  assign sweep_last = (sweep_addr == ADDR_W'(DEPTH - 1));
  assign sweeping   = (state == S_SWEEP);
  assign clr_busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clr_start) state_nxt = S_DRAIN;
      // Nothing is accepted in DRAIN, so stage 1 holds at most the op taken
      // in the last idle cycle and it commits by the end of this cycle.
      S_DRAIN: state_nxt = S_SWEEP;
      S_SWEEP: if (sweep_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || !sweeping) sweep_addr <= '0;
    else                     sweep_addr <= sweep_addr + 1'b1;
  end

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk) begin
    if (!reset) s1_valid <= 1'b0;
    else        s1_valid <= rd_fire | acc_fire;
  end

  always_ff @(posedge clk) begin
    s1_op    <= rd_fire ? OP_RD : OP_ACC;
    s1_addr  <= req_addr;
    s1_val   <= acc_val;
    s1_clear <= rd_clear;
  end

  // The RAM read of this op raced the write committed on the same edge;
  // the forward register holds exactly that write.
  assign old_val = (fwd_valid && fwd_addr == s1_addr) ? fwd_data : ram_q;
  assign sres    = sat_add(32'(old_val), 32'(s1_val), DATA_W);
  assign new_val = (s1_op == OP_ACC) ? sres.value[DATA_W-1:0] : '0;
  assign s1_wr   = s1_valid & ((s1_op == OP_ACC) | s1_clear);
  // Clamped result always fits DATA_W; the upper bits are sign copies.
  assign sres_unused = ^sres.value[31:DATA_W];

  assign rsp_valid = s1_valid & (s1_op == OP_RD);
  assign rsp_data  = rsp_valid ? old_val : '0;
  assign sat_event = s1_valid & (s1_op == OP_ACC) & sres.sat;

  // ---------------- write port ----------------
  // Sweep and stage-1 writes never overlap: DRAIN empties stage 1 first.
  assign we    = reset & (sweeping | s1_wr);
  assign waddr = sweeping ? sweep_addr : s1_addr;
  assign wdata = sweeping ? '0 : new_val;

  always_ff @(posedge clk) begin
    if (!reset)  fwd_valid <= 1'b0;
    else if (we) fwd_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      fwd_addr <= waddr;
      fwd_data <= wdata;
    end
  end

  dp_ram_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (req_addr),
    .q     (ram_q)
  );

endmodule
